// File: rtl/hub_downstream_router.sv
// Hub downstream router: holds one message and delivers it to one link (unicast)
// or to every link (broadcast) under independent per-link backpressure.

module hub_downstream_lane (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic load_bit,
    input  logic ready,
    output logic pending,
    output logic block
);
    always_ff @(posedge clk) begin
        if (reset)
            pending <= 1'b0;
        else if (load)
            pending <= load_bit;
        else if (pending & ready)
            pending <= 1'b0;
    end

    // This link is still owed the held message and will not take it this cycle.
    assign block = pending & ~ready;
endmodule

module hub_downstream_router #(
    parameter int HUB_FIFO_WIDTH        = 32,
    parameter int DOWNSTREAM_FIFO_COUNT = 4,
    parameter int FPGAID_WIDTH          = 4,
    parameter int FPGA_ID               = 0,
    parameter int DROP_COUNTER_WIDTH    = 8
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic [HUB_FIFO_WIDTH-1:0]                       in_data,
    input  logic                                            in_valid,
    output logic                                            in_ready,
    output logic [DOWNSTREAM_FIFO_COUNT*HUB_FIFO_WIDTH-1:0] out_data,
    output logic [DOWNSTREAM_FIFO_COUNT-1:0]                out_valid,
    input  logic [DOWNSTREAM_FIFO_COUNT-1:0]                out_ready,
    output logic                                            busy,
    output logic [DROP_COUNTER_WIDTH-1:0]                   drop_count
);
    localparam int IDW = FPGAID_WIDTH + 1;
    localparam logic [IDW-1:0] ID_LO = IDW'(FPGA_ID + 1);
    localparam logic [IDW-1:0] ID_HI = IDW'(FPGA_ID + DOWNSTREAM_FIFO_COUNT);

    logic [HUB_FIFO_WIDTH-1:0]        hold_reg;
    logic                             hold_valid;
    logic [DOWNSTREAM_FIFO_COUNT-1:0] pending;
    logic [DOWNSTREAM_FIFO_COUNT-1:0] block;

    logic [FPGAID_WIDTH-1:0] dest;
    logic [IDW-1:0]          dest_ext;
    logic [IDW-1:0]          link_idx;
    logic                    is_bcast;
    logic                    is_map;
    logic                    keep;
    logic                    accept;
    logic                    load;
    logic                    done_now;

    // Decode is extended by one bit so FPGA_ID+COUNT cannot wrap.
    assign dest     = in_data[HUB_FIFO_WIDTH-1 -: FPGAID_WIDTH];
    assign dest_ext = {1'b0, dest};
    assign link_idx = dest_ext - ID_LO;
    assign is_bcast = &dest;
    assign is_map   = (dest_ext >= ID_LO) && (dest_ext <= ID_HI);
    assign keep     = is_bcast | is_map;

    assign done_now = hold_valid & ~(|block);
    assign in_ready = ~hold_valid | done_now;
    assign accept   = in_valid & in_ready;
    assign load     = accept & keep;
    assign busy     = hold_valid | in_valid;

    for (genvar p = 0; p < DOWNSTREAM_FIFO_COUNT; p++) begin : g_lane
        hub_downstream_lane u_lane (
            .clk      (clk),
            .reset    (reset),
            .load     (load),
            .load_bit (is_bcast | (is_map & (link_idx == IDW'(p)))),
            .ready    (out_ready[p]),
            .pending  (pending[p]),
            .block    (block[p])
        );
        assign out_valid[p]                          = hold_valid & pending[p];
        assign out_data[p*HUB_FIFO_WIDTH +: HUB_FIFO_WIDTH] = hold_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_reg   <= '0;
            hold_valid <= 1'b0;
            drop_count <= '0;
        end else begin
            if (load) begin
                hold_reg   <= in_data;
                hold_valid <= 1'b1;
            end else if (done_now) begin
                hold_valid <= 1'b0;
            end
            if (accept && !keep && (drop_count != '1))
                drop_count <= drop_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_hub_downstream_router.sv
// Bench for hub_downstream_router: directed cases plus random traffic against
// per-link expected-message queues.

module tb_hub_downstream_router;
    localparam int W = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [W-1:0]   in_data;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] out_data;
    logic [N-1:0]   out_valid;
    logic [N-1:0]   out_ready;
    logic           busy;
    logic [7:0]     drop_count;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] q [N][$];
    int           exp_drop = 0;

    always #5 clk = ~clk;

    hub_downstream_router #(
        .HUB_FIFO_WIDTH(W), .DOWNSTREAM_FIFO_COUNT(N), .FPGAID_WIDTH(4),
        .FPGA_ID(0), .DROP_COUNTER_WIDTH(8)
    ) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .drop_count(drop_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, want);
        end
    endtask

    // One clock: check outputs against the queues, then apply the edge to the model.
    task automatic cyc(output logic accepted);
        logic [N-1:0] ev;
        logic         rdy;
        logic [3:0]   d;
        #1;
        ev  = '0;
        rdy = 1'b1;
        for (int p = 0; p < N; p++) begin
            if (q[p].size() != 0) begin
                ev[p] = 1'b1;
                if (!out_ready[p]) rdy = 1'b0;
            end
        end
        chk("in_ready", 64'(in_ready), 64'(rdy));
        chk("out_valid", 64'(out_valid), 64'(ev));
        chk("busy", 64'(busy), 64'((|ev) | in_valid));
        chk("drop_count", 64'(drop_count), 64'(exp_drop));
        for (int p = 0; p < N; p++)
            if (ev[p]) chk("out_data", 64'(out_data[p*W +: W]), 64'(q[p][0]));
        accepted = in_valid & rdy & ~reset;
        d = in_data[W-1 -: 4];
        @(posedge clk);
        if (reset) begin
            for (int p = 0; p < N; p++) q[p].delete();
            exp_drop = 0;
        end else begin
            for (int p = 0; p < N; p++)
                if (ev[p] && out_ready[p]) void'(q[p].pop_front());
            if (accepted) begin
                if (d == 4'hF)
                    for (int p = 0; p < N; p++) q[p].push_back(in_data);
                else if (d >= 1 && d <= N)
                    q[d-1].push_back(in_data);
                else if (exp_drop < 255)
                    exp_drop++;
            end
        end
        #1;
    endtask

    initial begin
        logic acc;
        int   accepted_n;
        int   cycles;
        int   r;
        logic [3:0] d;

        reset = 1'b1; in_valid = 1'b1; in_data = '0; out_ready = '0;
        @(posedge clk); #1;
        cyc(acc);
        chk("rst_out_data", 64'(out_data == '0), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        reset = 1'b0; in_valid = 1'b0;
        cyc(acc);

        // Unicast to link 1, visible for exactly one cycle
        in_data = 32'h2000_0ABC; in_valid = 1'b1; out_ready = 4'hF;
        cyc(acc);
        in_valid = 1'b0;
        chk("uni_valid", 64'(out_valid), 64'b0010);
        chk("uni_data", 64'(out_data[1*W +: W]), 64'h2000_0ABC);
        cyc(acc);
        chk("uni_gone", 64'(out_valid), 64'd0);

        // Broadcast with partial readiness
        in_data = 32'hF000_0123; in_valid = 1'b1;
        cyc(acc);
        in_valid = 1'b0; out_ready = 4'b0101; #1;
        chk("bc_valid1", 64'(out_valid), 64'b1111);
        chk("bc_ready1", 64'(in_ready), 64'd0);
        cyc(acc);
        out_ready = 4'b1111; #1;
        chk("bc_valid2", 64'(out_valid), 64'b1010);
        chk("bc_ready2", 64'(in_ready), 64'd1);
        cyc(acc);
        chk("bc_valid3", 64'(out_valid), 64'd0);

        // Unmapped destination: drop counter saturates
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_data = 32'h7000_0000 | 32'(i);
            cyc(acc);
        end
        in_valid = 1'b0; #1;
        chk("drop_sat", 64'(drop_count), 64'd255);
        chk("drop_novalid", 64'(out_valid), 64'd0);

        // Back-to-back unicasts, one per cycle
        in_valid = 1'b1;
        for (int k = 0; k < N; k++) begin
            in_data = {4'(k + 1), 28'(32'h100 + k)};
            cyc(acc);
            chk("b2b_acc", 64'(acc), 64'd1);
            chk("b2b_valid", 64'(out_valid), 64'(1 << k));
        end
        in_valid = 1'b0;
        cyc(acc);

        // Reset with a partially delivered broadcast
        in_data = 32'hF000_0456; in_valid = 1'b1; out_ready = '0;
        cyc(acc);
        in_valid = 1'b0; out_ready = 4'b0011;
        cyc(acc);
        reset = 1'b1; out_ready = '0; #1;
        chk("rst_mid_valid", 64'(out_valid), 64'b1100);
        cyc(acc);
        reset = 1'b0; #1;
        chk("post_rst_valid", 64'(out_valid), 64'd0);
        chk("post_rst_ready", 64'(in_ready), 64'd1);
        in_data = 32'h3000_0777; in_valid = 1'b1; out_ready = 4'hF;
        cyc(acc);
        in_valid = 1'b0;
        chk("post_rst_uni", 64'(out_valid), 64'b0100);
        cyc(acc);
        chk("post_rst_once", 64'(out_valid), 64'd0);

        // Random traffic with random per-link stalls
        accepted_n = 0;
        cycles = 0;
        while (accepted_n < 1000 && cycles < 30000) begin
            r = int'($urandom % 8);
            if (r < 4)       d = 4'(r + 1);
            else if (r == 4) d = 4'hF;
            else if (r == 5) d = 4'($urandom_range(5, 14));
            else if (r == 6) d = 4'h0;
            else             d = 4'($urandom_range(1, 4));
            in_data   = {d, 28'($urandom)};
            in_valid  = ($urandom % 10) < 7;
            out_ready = 4'($urandom);
            cyc(acc);
            if (acc) accepted_n++;
            cycles++;
        end
        chk("rand_timeout", 64'(accepted_n >= 1000), 64'd1);
        in_valid = 1'b0; out_ready = 4'hF;
        for (int i = 0; i < 3; i++) cyc(acc);
        chk("rand_drained", 64'(q[0].size() + q[1].size() + q[2].size() + q[3].size()), 64'd0);
        chk("rand_idle", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
